// File: rtl/req_encoder_if.sv
// req_encoder_if: request inputs, issued-code handshake and status bus of the request encoder
interface req_encoder_if #(
  parameter int WIDTH  = 8,
  parameter int CODE_W = 3,
  parameter int CNT_W  = 8
);
  logic [WIDTH-1:0]  req_in;
  logic [CODE_W-1:0] out_code;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  pending;
  logic [CODE_W:0]   pending_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  modport master (
    output req_in, out_ready,
    input  out_code, out_valid, pending, pending_cnt, drop_cnt
  );
  modport slave (
    input  req_in, out_ready,
    output out_code, out_valid, pending, pending_cnt, drop_cnt
  );
endinterface

// File: rtl/req_encoder.sv
// req_encoder: accumulates request pulses and issues their indices lowest-first over valid/ready
module req_encoder #(
  parameter int WIDTH  = 8,
  parameter int CODE_W = 3,
  parameter int CNT_W  = 8
) (
  input logic          clk,
  input logic          rst,
  req_encoder_if.slave bus
);
  logic [WIDTH-1:0]  pending_q, pending_d, clr_mask, cand, drops;
  logic [CODE_W-1:0] out_code_q, out_code_d, low;
  logic              out_valid_q, out_valid_d, accept, load;
  logic [CODE_W:0]   pending_cnt_q, pending_cnt_d, drop_sum;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W:0]    drop_wide;
  always_comb begin
    accept        = out_valid_q && bus.out_ready;
    clr_mask      = accept ? WIDTH'(1) << out_code_q : '0;
    cand          = pending_q & ~clr_mask;
    pending_d     = cand | bus.req_in;
    drops         = bus.req_in & cand;
    low           = '0;
    pending_cnt_d = '0;
    drop_sum      = '0;
    // descending scan so the lowest set index is the last one written
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (cand[i]) low = CODE_W'(i);
      pending_cnt_d = pending_cnt_d + (CODE_W+1)'(pending_d[i]);
      drop_sum      = drop_sum + (CODE_W+1)'(drops[i]);
    end
    load        = !out_valid_q || accept;
    out_valid_d = load ? |cand : out_valid_q;
    out_code_d  = load && |cand ? low : out_code_q;
    drop_wide   = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_sum);
    drop_cnt_d  = drop_wide[CNT_W] ? '1 : drop_wide[CNT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= '0;
      pending_cnt_q <= '0;
      out_valid_q   <= 1'b0;
      out_code_q    <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pending_q     <= pending_d;
      pending_cnt_q <= pending_cnt_d;
      out_valid_q   <= out_valid_d;
      out_code_q    <= out_code_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end
  assign bus.pending     = pending_q;
  assign bus.pending_cnt = pending_cnt_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_code    = out_code_q;
  assign bus.drop_cnt    = drop_cnt_q;
endmodule

// File: doc/req_encoder.md
# req_encoder

Sequential 8:3 request encoder: the inverse of the team's 3-to-8 one-hot decoder. It accumulates one-hot or multi-hot request pulses into a pending register. It then issues their 3-bit indices one at a time, lowest index first, over a registered valid/ready handshake. The block sits between event sources (interrupt lines, per-channel done strobes) and any consumer that wants a serialized binary channel ID. At the far end, that ID can be re-expanded by the decoder.

## Interface
Parameters:
- WIDTH, 8, number of request lines; fixed at 8 for this revision.
- CODE_W, 3, output code width; must equal clog2(WIDTH).
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock domain, all state updates on rising edge.
- rst  input  1  reset is synchronous and active-high.
- req_in  input  WIDTH  request pulses; bit i high for one or more cycles = request for index i.
- out_code  output  CODE_W  binary index of the issued request; registered.
- out_valid  output  1  out_code is valid; registered.
- out_ready  input  1  consumer accepts when out_valid && out_ready at a rising edge.
- pending  output  WIDTH  current pending register (issued-but-unaccepted bit included).
- pending_cnt  output  CODE_W+1  population count of pending, registered alongside pending.
- drop_cnt  output  CNT_W  saturating count of request bits merged into an already-pending bit.

## Operation
- accept = out_valid && out_ready. clr_mask = accept ? onehot(out_code) : 0.
- pending update: pending_n = (pending & ~clr_mask) | req_in.
  - A req_in bit set in the same cycle its index is accepted stays pending and is re-issued later.
- Output slot, evaluated when !out_valid || accept:
  - cand = pending & ~clr_mask (req_in of this cycle excluded).
  - If cand != 0: out_valid_n = 1, out_code_n = index of lowest set bit of cand.
  - Else: out_valid_n = 0, out_code_n holds its previous value.
- While out_valid && !out_ready, out_code and out_valid hold. A new lower-index request never pre-empts an issued code.
- Priority: index 0 highest, index 7 lowest. Strict priority is the intended behaviour; starvation of high indices under continuous low-index traffic is accepted.
- Drop counting: for each bit i with req_in[i] && pending[i] && !clr_mask[i], add 1 to drop_cnt.
  - Multiple bits in one cycle add their total.
  - drop_cnt saturates at 2^CNT_W-1 and never wraps.
- pending_cnt = popcount(pending_n), registered, range 0..8.
- Two-state view:
  - EMPTY (out_valid=0) -> ISSUE when cand != 0.
  - ISSUE -> ISSUE on accept with remaining cand.
  - ISSUE -> EMPTY on accept with cand == 0.
  - ISSUE holds without accept.

## Timing
- Reset (rst high at an edge): pending=0, pending_cnt=0, out_valid=0, out_code=0, drop_cnt=0. Reset takes priority over every other update.
  - Reset mid-operation discards pending requests and any issued-but-unaccepted code.
  - req_in is ignored in reset cycles.
- Latency with an empty block: req_in[i] high before edge N -> pending[i]=1 after edge N -> out_valid=1, out_code=i after edge N+1. Two cycles from request to valid.
- Throughput: with out_ready held high and k bits pending, one code is issued per cycle, back-to-back, with no bubble.
- After the final accept, out_valid drops at that same edge.
- Simultaneous request and accept of the same index: bit remains pending; it is re-issued no earlier than the next slot load.
- All-ones req_in in one cycle: pending=0xFF, pending_cnt=8. Codes are issued 0..7 in order.
- Outputs depend only on registers; there is no combinational path from req_in or out_ready to any output.

## Test plan
- Reset/idle: assert rst 2 cycles with req_in=0xFF -> after release, pending=0, out_valid=0, out_code=0, drop_cnt=0.
- Single request:
  - Stimulus: req_in=0x20 for 1 cycle, out_ready=1.
  - Required response: out_valid rises 2 edges later with out_code=5, pending_cnt=1; both clear the cycle after the accept.
- Burst ordering:
  - Stimulus: req_in=0xA5 for 1 cycle, out_ready=1.
  - Required response: codes 0,2,5,7 on consecutive cycles, then out_valid=0 and pending=0.
- Backpressure stability:
  - Stimulus: req_in=0x08, out_ready=0 for 5 cycles, then req_in=0x01 while stalled.
  - Required response: out_code stays 3 throughout the stall. After out_ready=1, the sequence is 3 then 0.
- Drops and re-request:
  - Hold req_in=0x02 for 4 cycles with out_ready=0 -> drop_cnt=3.
  - Then pulse req_in=0x02 in the same cycle out_ready=1 accepts code 1 -> code 1 is issued again afterwards, and drop_cnt stays 3.
- Reset mid-burst: load 0xFF, accept 3 codes, assert rst -> pending=0, out_valid=0; no further codes are issued.
